master_wr_mem_control: RTL and testbench

- Write-side counterpart of the master memory read controller.
- Drains a diagonally skewed result wavefront from the systolic array into per-column output memories. Column c produces row r of the result tile at write cycle t = r + c.
- Generates per-column write enables and per-column write addresses.
- Sits between the top-level master FSM, which pulses active, and the output memory bank.

---
 rtl/master_wr_mem_control_if.sv | 30 +++
 rtl/master_wr_mem_control.sv | 100 ++++++++++
 tb/tb_master_wr_mem_control.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/master_wr_mem_control_if.sv
// Bundle between the master FSM / output memory bank and the write controller.
// The controller takes the slave modport; the master FSM side takes the master modport.
interface master_wr_mem_control_if #(
   parameter int ADDR_WIDTH   = 8,
   parameter int WIDTH_HEIGHT = 16
);
   localparam int CW = $clog2(WIDTH_HEIGHT);

   // Handshake: active is a start request that is accepted on any clock edge where busy is low.
   // busy stays high from the accepting edge through the done cycle. done pulses for exactly one cycle per tile.
   logic                               active;
   logic [ADDR_WIDTH-1:0]              base_addr;
   logic [CW-1:0]                      num_row;
   logic [CW-1:0]                      num_col;
   logic [ADDR_WIDTH*WIDTH_HEIGHT-1:0] out_addr;
   logic [WIDTH_HEIGHT-1:0]            out_wr_en;
   logic                               busy;
   logic                               done;
   logic [1:0]                         state_dbg;

   modport master (
      output active, base_addr, num_row, num_col,
      input  out_addr, out_wr_en, busy, done, state_dbg
   );

   modport slave (
      input  active, base_addr, num_row, num_col,
      output out_addr, out_wr_en, busy, done, state_dbg
   );
endinterface

// File: rtl/master_wr_mem_control.sv
// Drains a diagonally skewed systolic result wavefront into per-column output memories.
// Column c writes result row r at write cycle t = r + c. All outputs are decoded from registered state.
module master_wr_mem_control #(
   parameter int ADDR_WIDTH   = 8,
   parameter int WIDTH_HEIGHT = 16,
   parameter int LEAD_CYCLES  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   master_wr_mem_control_if.slave   bus
);
   localparam int CW = $clog2(WIDTH_HEIGHT);
   localparam int TW = CW + 1;
   localparam int LW = (LEAD_CYCLES > 1) ? $clog2(LEAD_CYCLES) : 1;
   localparam logic [LW-1:0] LEAD_LAST = LW'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state;
   logic [LW-1:0]         lead_cnt;
   logic [TW-1:0]         t;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [CW-1:0]         num_row_q;
   logic [CW-1:0]         num_col_q;
   logic [TW-1:0]         t_last;

   assign t_last = {1'b0, num_row_q} + {1'b0, num_col_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         lead_cnt  <= '0;
         t         <= '0;
         base_q    <= '0;
         num_row_q <= '0;
         num_col_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.active) begin
                  base_q    <= bus.base_addr;
                  num_row_q <= bus.num_row;
                  num_col_q <= bus.num_col;
                  lead_cnt  <= '0;
                  t         <= '0;
                  state     <= (LEAD_CYCLES == 0) ? S_WRITE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (lead_cnt == LEAD_LAST) begin
                  lead_cnt <= '0;
                  t        <= '0;
                  state    <= S_WRITE;
               end else begin
                  lead_cnt <= lead_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               if (t == t_last) begin
                  state <= S_DONE;
               end else begin
                  t <= t + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   logic [WIDTH_HEIGHT-1:0]            en_vec;
   logic [ADDR_WIDTH*WIDTH_HEIGHT-1:0] addr_vec;

   // Column c is on the wavefront when its row index t-c lies inside the latched tile.
   always_comb begin
      en_vec   = '0;
      addr_vec = '0;
      for (int c = 0; c < WIDTH_HEIGHT; c++) begin
         logic [TW-1:0] col;
         logic [TW-1:0] row;
         col = TW'(c);
         row = t - col;
         if ((state == S_WRITE) && (col <= {1'b0, num_col_q}) && (t >= col) &&
             (row <= {1'b0, num_row_q})) begin
            en_vec[c] = 1'b1;
            addr_vec[c*ADDR_WIDTH +: ADDR_WIDTH] = base_q + ADDR_WIDTH'(row);
         end
      end
   end

   assign bus.out_wr_en = en_vec;
   assign bus.out_addr  = addr_vec;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_master_wr_mem_control.sv
// Bench for master_wr_mem_control: two instances (lead 2 and lead 0), random tiles,
// expected writes pushed per tile and popped by per-instance monitors.
module tb_master_wr_mem_control;
  localparam int AW = 8;
  localparam int W = 4;
  localparam int LEAD0 = 2;
  localparam int LEAD1 = 0;
  localparam int EW = 53;
  localparam int NCYC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int free_c[2];
  int junk_mode[2];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  bit busy_exp0[0:NCYC-1];
  bit busy_exp1[0:NCYC-1];

  master_wr_mem_control_if #(.ADDR_WIDTH(AW), .WIDTH_HEIGHT(W)) bus0();
  master_wr_mem_control_if #(.ADDR_WIDTH(AW), .WIDTH_HEIGHT(W)) bus1();

  master_wr_mem_control #(.ADDR_WIDTH(AW), .WIDTH_HEIGHT(W), .LEAD_CYCLES(LEAD0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  master_wr_mem_control #(.ADDR_WIDTH(AW), .WIDTH_HEIGHT(W), .LEAD_CYCLES(LEAD1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_note(input string name, input int at);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d actual=none required=entry_at_%0d", name, cyc, at);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input int id, input logic act, input logic [AW-1:0] b,
                       input logic [1:0] nr, input logic [1:0] nc);
    if (id == 0) begin
      bus0.active = act; bus0.base_addr = b; bus0.num_row = nr; bus0.num_col = nc;
    end else begin
      bus1.active = act; bus1.base_addr = b; bus1.num_row = nr; bus1.num_col = nc;
    end
  endtask

  task automatic junk(input int id);
    logic act;
    case (junk_mode[id])
      0: act = 1'b0;
      1: act = 1'($urandom_range(0, 1));
      default: act = 1'b1;
    endcase
    drive(id, act, AW'($urandom), 2'($urandom), 2'($urandom));
  endtask

  task automatic wait_free(input int id);
    while (cyc + 1 < free_c[id]) begin
      junk(id);
      step();
    end
  endtask

  // reference model: every (row, col) element lands at cycle start+lead+row+col
  task automatic model_push(input int id, input int k, input logic [AW-1:0] b,
                            input logic [1:0] nr, input logic [1:0] nc);
    logic [W-1:0] en_a[7];
    logic [AW*W-1:0] ad_a[7];
    int lead, span;
    lead = (id == 0) ? LEAD0 : LEAD1;
    span = int'(nr) + int'(nc) + 1;
    for (int i = 0; i < 7; i++) begin
      en_a[i] = '0;
      ad_a[i] = '0;
    end
    for (int r = 0; r <= int'(nr); r++)
      for (int c = 0; c <= int'(nc); c++) begin
        en_a[r + c][c] = 1'b1;
        ad_a[r + c][c*AW +: AW] = b + AW'(r);
      end
    for (int t = 0; t < span; t++) begin
      if (id == 0) exp_q0.push_back({16'(k + lead + t), 1'b0, en_a[t], ad_a[t]});
      else         exp_q1.push_back({16'(k + lead + t), 1'b0, en_a[t], ad_a[t]});
    end
    if (id == 0) exp_q0.push_back({16'(k + lead + span), 1'b1, {W{1'b0}}, {(AW*W){1'b0}}});
    else         exp_q1.push_back({16'(k + lead + span), 1'b1, {W{1'b0}}, {(AW*W){1'b0}}});
    for (int n = k; n <= k + lead + span; n++) begin
      if (id == 0) busy_exp0[n] = 1'b1;
      else         busy_exp1[n] = 1'b1;
    end
    free_c[id] = k + lead + span + 2;
  endtask

  task automatic issue(input int id, input logic [AW-1:0] b, input logic [1:0] nr, input logic [1:0] nc);
    int k;
    wait_free(id);
    k = cyc + 1;
    model_push(id, k, b, nr, nc);
    drive(id, 1'b1, b, nr, nc);
    step();
    junk(id);
  endtask

  // start a tile on instance 0, then reset during its t=2 write cycle
  task automatic abort0(input logic [AW-1:0] b, input logic [1:0] nr, input logic [1:0] nc);
    int k, w, d;
    logic [EW-1:0] e;
    issue(0, b, nr, nc);
    k = cyc;
    w = k + LEAD0 + 2;
    d = free_c[0] - 2;
    while (cyc < w) begin
      junk(0);
      step();
    end
    while (exp_q0.size() > 0) begin
      e = exp_q0[$];
      if (int'(e[52:37]) <= w) break;
      void'(exp_q0.pop_back());
    end
    for (int n = w + 1; n <= d; n++) busy_exp0[n] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    junk_mode[0] = 0;
    junk(0);
    free_c[0] = w + 2;
  endtask

  // scoreboard monitors
  logic [EW-1:0] ent0, ent1;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy0", 64'(bus0.busy), 64'(busy_exp0[cyc % NCYC]));
      while (exp_q0.size() > 0) begin
        ent0 = exp_q0[0];
        if (int'(ent0[52:37]) >= cyc) break;
        void'(exp_q0.pop_front());
        fail_note("missed0", int'(ent0[52:37]));
      end
      if (bus0.out_wr_en != '0 || bus0.out_addr != '0 || bus0.done) begin
        if (exp_q0.size() == 0) begin
          fail_note("unexpected0", cyc);
        end else begin
          ent0 = exp_q0.pop_front();
          check("cycle0", 64'(cyc), 64'(ent0[52:37]));
          check("done0", 64'(bus0.done), 64'(ent0[36]));
          check("en0", 64'(bus0.out_wr_en), 64'(ent0[35:32]));
          check("addr0", 64'(bus0.out_addr), 64'(ent0[31:0]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy1", 64'(bus1.busy), 64'(busy_exp1[cyc % NCYC]));
      while (exp_q1.size() > 0) begin
        ent1 = exp_q1[0];
        if (int'(ent1[52:37]) >= cyc) break;
        void'(exp_q1.pop_front());
        fail_note("missed1", int'(ent1[52:37]));
      end
      if (bus1.out_wr_en != '0 || bus1.out_addr != '0 || bus1.done) begin
        if (exp_q1.size() == 0) begin
          fail_note("unexpected1", cyc);
        end else begin
          ent1 = exp_q1.pop_front();
          check("cycle1", 64'(cyc), 64'(ent1[52:37]));
          check("done1", 64'(bus1.done), 64'(ent1[36]));
          check("en1", 64'(bus1.out_wr_en), 64'(ent1[35:32]));
          check("addr1", 64'(bus1.out_addr), 64'(ent1[31:0]));
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] b;
    free_c[0] = 0;
    free_c[1] = 0;
    junk_mode[0] = 0;
    junk_mode[1] = 0;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_en0", 64'(bus0.out_wr_en), 64'd0);
    check("rst_addr0", 64'(bus0.out_addr), 64'd0);
    check("rst_busy0", 64'(bus0.busy), 64'd0);
    check("rst_done0", 64'(bus0.done), 64'd0);
    check("rst_en1", 64'(bus1.out_wr_en), 64'd0);
    check("rst_busy1", 64'(bus1.busy), 64'd0);
    step();
    reset = 1'b0;
    mon_en = 1'b1;

    // skew pattern, address wrap, full tile
    issue(0, 8'h10, 2'd1, 2'd2);
    issue(0, 8'hFF, 2'd2, 2'd0);
    b = AW'($urandom);
    issue(0, b, 2'd3, 2'd3);

    // reset at t=2 of a full tile, then the same tile cleanly
    abort0(b, 2'd3, 2'd3);
    issue(0, b, 2'd3, 2'd3);

    // random tiles with inputs churning while busy
    junk_mode[0] = 1;
    for (int i = 0; i < 20; i++)
      issue(0, AW'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    junk_mode[0] = 0;
    wait_free(0);
    junk(0);

    // lead 0: 1x1 tiles with active held high back to back
    junk_mode[1] = 2;
    for (int i = 0; i < 4; i++) issue(1, AW'($urandom), 2'd0, 2'd0);
    junk_mode[1] = 1;
    for (int i = 0; i < 10; i++)
      issue(1, AW'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    junk_mode[1] = 0;
    junk(1);
    wait_free(1);
    junk(1);

    repeat (4) step();
    @(negedge clk);
    check("drain0", 64'(exp_q0.size()), 64'd0);
    check("drain1", 64'(exp_q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
